// File: rtl/instr_encoder_loader.sv
// Encodes symbolic MIPS instructions and loads the resulting words into
// instruction memory at consecutive addresses through a hold-until-ack port.
module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [25:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   state_t      state;
   logic        finish_pending;
   logic        accept;
   logic        kind_legal;
   logic [31:0] encoded;

   assign in_ready   = (state == LOAD) && (count < DEPTH);
   assign accept     = in_valid && in_ready;
   assign kind_legal = (in_kind <= 4'd8);

   // R-type words carry op 0 and select the ALU operation through funct.
   always_comb begin
      encoded = 32'd0;
      case (in_kind)
         4'd0:    encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
         4'd1:    encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
         4'd2:    encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
         4'd3:    encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
         4'd4:    encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
         4'd5:    encoded = {6'h23, in_rs, in_rt, in_imm[15:0]};
         4'd6:    encoded = {6'h2B, in_rs, in_rt, in_imm[15:0]};
         4'd7:    encoded = {6'h04, in_rs, in_rt, in_imm[15:0]};
         4'd8:    encoded = {6'h02, in_imm};
         default: encoded = 32'd0;
      endcase
   end

   // A finish seen in LOAD with a beat, or anywhere during WRITE, is held
   // until the outstanding word has been acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= 32'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         count          <= '0;
         finish_pending <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= LOAD;
                  busy           <= 1'b1;
                  count          <= '0;
                  err            <= 1'b0;
                  finish_pending <= 1'b0;
               end
            end
            LOAD: begin
               if (accept && kind_legal) begin
                  state          <= WRITE;
                  mem_we         <= 1'b1;
                  mem_addr       <= count[ADDR_W-1:0];
                  mem_wdata      <= encoded;
                  finish_pending <= finish;
               end else begin
                  if (accept) begin
                     err <= 1'b1;
                  end
                  if (finish) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_we <= 1'b0;
                  count  <= count + (ADDR_W+1)'(1);
                  if (finish_pending || finish) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= LOAD;
                  end
               end else if (finish) begin
                  finish_pending <= 1'b1;
               end
            end
            DONE: begin
               state          <= IDLE;
               busy           <= 1'b0;
               finish_pending <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a wide instance for encoding and sessions,
// and a 4-word instance for the full condition, sharing the input stimulus.
module tb_instr_encoder_loader;

   logic        clk;
   logic        rst;
   logic        start_b;
   logic        start_s;
   logic        finish;
   logic        in_valid;
   logic [3:0]  in_kind;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [25:0] in_imm;
   logic        mem_ack;

   logic        b_in_ready, b_mem_we, b_busy, b_done, b_err;
   logic [7:0]  b_mem_addr;
   logic [31:0] b_mem_wdata;
   logic [8:0]  b_count;

   logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
   logic [1:0]  s_mem_addr;
   logic [31:0] s_mem_wdata;
   logic [2:0]  s_count;

   logic        sel;
   logic        cur_ready, cur_we, cur_busy, cur_done, cur_err;
   logic [7:0]  cur_addr;
   logic [31:0] cur_wdata;
   logic [8:0]  cur_count;

   int checks = 0;
   int errors = 0;
   int modelCount;
   int modelErr;

   instr_encoder_loader #(.ADDR_W(8)) dutBig (
      .clk(clk), .rst(rst), .start(start_b), .finish(finish),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_ack(mem_ack), .busy(b_busy), .done(b_done), .err(b_err),
      .count(b_count)
   );

   instr_encoder_loader #(.ADDR_W(2)) dutSmall (
      .clk(clk), .rst(rst), .start(start_s), .finish(finish),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_ack(mem_ack), .busy(s_busy), .done(s_done), .err(s_err),
      .count(s_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Select which instance the checks observe.
   always_comb begin
      cur_ready = sel ? s_in_ready : b_in_ready;
      cur_we    = sel ? s_mem_we : b_mem_we;
      cur_busy  = sel ? s_busy : b_busy;
      cur_done  = sel ? s_done : b_done;
      cur_err   = sel ? s_err : b_err;
      cur_addr  = sel ? {6'd0, s_mem_addr} : b_mem_addr;
      cur_wdata = sel ? s_mem_wdata : b_mem_wdata;
      cur_count = sel ? {6'd0, s_count} : b_count;
   end

   // Reference encoder built from field weights rather than bit slicing.
   function automatic logic [31:0] refEncode(input longint kind, input longint rs,
                                             input longint rt, input longint rd,
                                             input longint imm);
      longint functs[5] = '{32, 34, 36, 37, 42};
      longint ops[3] = '{35, 43, 4};
      longint w;
      if (kind < 5)
         w = rs * 2097152 + rt * 65536 + rd * 2048 + functs[kind];
      else if (kind < 8)
         w = ops[kind - 5] * 67108864 + rs * 2097152 + rt * 65536 + (imm % 65536);
      else
         w = 2 * 67108864 + (imm % 67108864);
      return 32'(w);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic startSession();
      if (sel) start_s = 1'b1;
      else start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      start_s = 1'b0;
      modelCount = 0;
      modelErr   = 0;
      checkOutput("start_busy", cur_busy, 1);
      checkOutput("start_count", cur_count, 0);
      checkOutput("start_err", cur_err, 0);
   endtask

   task automatic presentBeat(input int kind, input int rs, input int rt, input int rd,
                              input int imm, input logic fin);
      int waited = 0;
      in_valid = 1'b1;
      in_kind  = 4'(kind);
      in_rs    = 5'(rs);
      in_rt    = 5'(rt);
      in_rd    = 5'(rd);
      in_imm   = 26'(imm);
      finish   = fin;
      while (!cur_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("ready_wait", cur_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      finish   = 1'b0;
   endtask

   // finMode: 0 none, 1 finish with the beat, 2 finish raised during WRITE.
   task automatic applyStimulus(input int kind, input int rs, input int rt, input int rd,
                                input int imm, input logic [31:0] expData,
                                input int finMode, input int ackDelay);
      int depth = sel ? 4 : 256;
      presentBeat(kind, rs, rt, rd, imm, finMode == 1);
      if (kind > 8) begin
         modelErr = 1;
         checkOutput("illegal_we", cur_we, 0);
         checkOutput("illegal_err", cur_err, 1);
         checkOutput("illegal_count", cur_count, 32'(modelCount));
         checkOutput("illegal_ready", cur_ready, 1);
      end else begin
         for (int d = 0; d <= ackDelay; d++) begin
            checkOutput("we_held", cur_we, 1);
            checkOutput("addr_held", cur_addr, 32'(modelCount));
            checkOutput("data_held", cur_wdata, expData);
            checkOutput("ready_low", cur_ready, 0);
            if (finMode == 2 && d == 1) finish = 1'b1;
            if (d == 2) finish = 1'b0;
            if (d == ackDelay) mem_ack = 1'b1;
            @(negedge clk);
         end
         mem_ack = 1'b0;
         finish  = 1'b0;
         modelCount++;
         checkOutput("we_drop", cur_we, 0);
         checkOutput("count_inc", cur_count, 32'(modelCount));
         checkOutput("err_state", cur_err, 32'(modelErr));
         if (finMode != 0) begin
            checkOutput("done_pulse", cur_done, 1);
            checkOutput("done_busy", cur_busy, 1);
            @(negedge clk);
            checkOutput("done_clear", cur_done, 0);
            checkOutput("idle_busy", cur_busy, 0);
         end else begin
            checkOutput("load_ready", cur_ready, 32'(modelCount < depth));
         end
      end
   endtask

   task automatic endSession(input logic withValid);
      finish   = 1'b1;
      in_valid = withValid;
      in_kind  = 4'd0;
      @(negedge clk);
      finish   = 1'b0;
      in_valid = 1'b0;
      checkOutput("end_done", cur_done, 1);
      checkOutput("end_busy", cur_busy, 1);
      @(negedge clk);
      checkOutput("end_done_clear", cur_done, 0);
      checkOutput("end_idle", cur_busy, 0);
      checkOutput("end_ready", cur_ready, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      rst = 1'b1; start_b = 1'b0; start_s = 1'b0; finish = 1'b0;
      in_valid = 1'b0; in_kind = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
      in_imm = 26'd0; mem_ack = 1'b0; sel = 1'b0;
      modelCount = 0; modelErr = 0;

      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checkOutput("rst_ready", cur_ready, 0);
         checkOutput("rst_we", cur_we, 0);
         checkOutput("rst_busy", cur_busy, 0);
         checkOutput("rst_done", cur_done, 0);
         checkOutput("rst_err", cur_err, 0);
         checkOutput("rst_count", cur_count, 0);
         checkOutput("rst_addr", cur_addr, 0);
         checkOutput("rst_wdata", cur_wdata, 0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] encoding of each legal kind");
      startSession();
      applyStimulus(0, 1, 2, 3, 0, 32'h00221820, 0, 0);
      applyStimulus(5, 29, 8, 0, 4, 32'h8FA80004, 0, 0);
      applyStimulus(6, 0, 5, 0, 16, 32'hAC050010, 0, 0);
      applyStimulus(7, 1, 2, 0, 65535, 32'h1022FFFF, 0, 0);
      applyStimulus(8, 0, 0, 0, 256, 32'h08000100, 0, 0);
      checkOutput("five_words", cur_count, 5);
      endSession(1'b0);

      $display("[TB] backpressure");
      startSession();
      applyStimulus(1, 4, 5, 6, 0, 32'h00853022, 0, 4);
      endSession(1'b0);

      $display("[TB] illegal kind between legal beats");
      startSession();
      applyStimulus(2, 7, 8, 9, 0, 32'h00E84824, 0, 1);
      applyStimulus(12, 1, 1, 1, 0, 32'h0, 0, 0);
      applyStimulus(3, 10, 11, 12, 0, 32'h014B6025, 0, 0);
      checkOutput("illegal_total", cur_count, 2);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      checkOutput("start_ignored_count", cur_count, 2);
      checkOutput("start_ignored_err", cur_err, 1);
      endSession(1'b0);
      checkOutput("err_sticky", cur_err, 1);

      $display("[TB] finish with last beat and during write");
      startSession();
      applyStimulus(4, 3, 4, 5, 0, 32'h0064282A, 1, 0);
      startSession();
      applyStimulus(6, 0, 5, 0, 16, 32'hAC050010, 2, 3);

      $display("[TB] randomized session");
      startSession();
      for (int i = 0; i < 24; i++) begin
         int k, rs, rt, rd, imm;
         k   = $urandom_range(0, 11);
         rs  = $urandom_range(0, 31);
         rt  = $urandom_range(0, 31);
         rd  = $urandom_range(0, 31);
         imm = $urandom_range(0, 67108863);
         applyStimulus(k, rs, rt, rd, imm, refEncode(k, rs, rt, rd, imm), 0,
                       $urandom_range(0, 3));
      end
      begin
         int k, rs, rt, imm;
         k   = $urandom_range(0, 8);
         rs  = $urandom_range(0, 31);
         rt  = $urandom_range(0, 31);
         imm = $urandom_range(0, 67108863);
         applyStimulus(k, rs, rt, 17, imm, refEncode(k, rs, rt, 17, imm), 1, 1);
      end

      $display("[TB] reset during a write");
      startSession();
      applyStimulus(15, 2, 2, 2, 0, 32'h0, 0, 0);
      presentBeat(8, 0, 0, 0, 67108863, 1'b0);
      checkOutput("pre_rst_we", cur_we, 1);
      checkOutput("pre_rst_data", cur_wdata, 32'h0BFFFFFF);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_we", cur_we, 0);
      checkOutput("async_busy", cur_busy, 0);
      checkOutput("async_err", cur_err, 0);
      checkOutput("async_wdata", cur_wdata, 0);
      checkOutput("async_ready", cur_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      startSession();
      applyStimulus(0, 1, 2, 3, 0, 32'h00221820, 1, 0);

      $display("[TB] full condition on the 4-word instance");
      sel = 1'b1;
      #1;
      startSession();
      for (int i = 0; i < 4; i++) begin
         int k, rs, rt, rd, imm;
         k   = $urandom_range(0, 8);
         rs  = $urandom_range(0, 31);
         rt  = $urandom_range(0, 31);
         rd  = $urandom_range(0, 31);
         imm = $urandom_range(0, 67108863);
         applyStimulus(k, rs, rt, rd, imm, refEncode(k, rs, rt, rd, imm), 0,
                       $urandom_range(0, 2));
      end
      in_valid = 1'b1;
      in_kind  = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("full_ready", cur_ready, 0);
         checkOutput("full_we", cur_we, 0);
         checkOutput("full_count", cur_count, 4);
         checkOutput("full_err", cur_err, 0);
      end
      endSession(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential MIPS instruction encoder and program loader. It accepts symbolic instructions over a valid/ready stream and encodes each into a 32-bit word whose opcode and funct fields the CPU control unit decodes: add, sub, and, or, slt, lw, sw, beq and j. It then writes each word into instruction memory at consecutive word addresses using a hold-until-ack write port. It sits between the testbench or boot source and the instruction memory, and loads programs before the CPU is released.

## Interface
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W words.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begins a load session at address 0; honoured only in IDLE.
- finish  in  1  ends the session once any pending write completes.
- in_valid  in  1  an instruction is presented.
- in_ready  out  1  the block accepts an instruction this cycle.
- in_kind  in  4  instruction kind: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 j; 9–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  26  immediate; bits [15:0] are used for lw, sw and beq, bits [25:0] for j.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  memory accepted the write; meaningful only while mem_we=1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a session ends.
- err  out  1  sticky error flag; cleared by rst or by an honoured start.
- count  out  ADDR_W+1  number of words written in this session.

## Operation
- States:
  - IDLE: start → LOAD, clearing count and err.
  - LOAD: a handshake with a legal kind → WRITE; finish with no handshake in that cycle → DONE.
  - WRITE: mem_ack → LOAD, or → DONE if a finish is pending.
  - DONE: always → IDLE after one cycle.
- Handshake: in_ready = (state==LOAD) && (count < 2^ADDR_W); a beat transfers on in_valid && in_ready at a clock edge.
- Encoding, with fields [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt=0, [5:0] funct:
  - R-type instructions use op 0 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw is op 0x23, sw is op 0x2B, beq is op 0x04; each takes rs, rt and imm[15:0].
  - j is op 0x02 with imm[25:0].
  - Fields not used by a kind are ignored.
- Illegal kind: the beat is consumed, nothing is written, err is set, count is unchanged, and the state stays LOAD.
- Address: mem_addr equals count[ADDR_W-1:0] at the time the beat is accepted. count increments on mem_ack.
- Full: when count = 2^ADDR_W, in_ready=0. Presenting in_valid in that state does not set err. The address does not wrap.
- finish:
  - If asserted in LOAD together with an accepted beat, that word is written and the block goes to DONE after its ack.
  - If asserted in WRITE, it is latched and the block goes to DONE after the ack.
  - If asserted in IDLE or DONE, it is ignored.
- start outside IDLE is ignored.
- done pulses only in DONE. busy=0 only in IDLE.

## Timing
- Reset values: state IDLE; in_ready, mem_we, busy, done and err are 0; count is 0; mem_addr and mem_wdata are 0.
- All outputs except in_ready are registered. in_ready is a combinational function of state and count only; it must not depend on in_valid.
- Beat accepted at edge t → mem_we=1 with stable mem_addr and mem_wdata from t+1 until the edge at which mem_ack=1 is sampled.
- That edge → mem_we=0 and count+1 in the next cycle.
- With mem_ack tied high, throughput is one word per 2 cycles.
- mem_ack while mem_we=0 has no effect.
- Asserting rst mid-write drops mem_we immediately (asynchronously) and returns to IDLE. The partial session is lost.

## Test plan
- Encoding of each legal kind after start:
  - add rs=1, rt=2, rd=3 → 0x00221820 at address 0.
  - lw rs=29, rt=8, imm=4 → 0x8FA80004.
  - sw rs=0, rt=5, imm=0x10 → 0xAC050010.
  - beq rs=1, rt=2, imm=0xFFFF → 0x1022FFFF.
  - j imm=0x100 → 0x08000100.
  - Addresses run 0–4 and count ends at 5.
- Backpressure: hold mem_ack low for 4 cycles → mem_we, mem_addr and mem_wdata stay constant and in_ready=0 throughout; one word is written after the ack.
- Illegal kind 12 between two legal beats → err=1, the legal words land at addresses 0 and 1, and count=2.
- Full condition with ADDR_W=2: four writes → count=4 and in_ready=0; a fifth valid is not accepted; finish → done pulses once and the block returns to IDLE.
- finish in the same cycle as the last beat → the word is written, done pulses one cycle after the ack, and busy then falls.
- rst asserted while mem_we=1 → all outputs take their reset values immediately; a subsequent start writes again from address 0 with err=0.
